// File: rtl/apu_gain_sequencer.sv
// -----------------------------------------------------------------------------
// apu_gain_sequencer
//
// Scales a stereo PCM frame by a gain factor taken from a 32-entry index table
// (index 19 = factor 32 = unity, result = factor * sample / 32 with saturation).
// A single signed 10x24 multiplier is shared between the channels: left is
// multiplied in MUL_L, right in MUL_R, and the frame is published in DONE.
// The gain index only moves in DONE, so both channels of a frame always use
// the same factor.
//
// Optional feature (compile-time macro APU_GAIN_RAMP_EN):
//   defined   : gain_idx_o steps by one toward the effective target once every
//               RAMP_DIV completed frames.
//   undefined : gain_idx_o loads the effective target in every DONE; RAMP_DIV
//               is only range-checked.
//
// Ports
//   MCLK_i                        audio master clock, rising edge
//   nRst_int_w                    asynchronous active-low reset
//   target_amp_i [4:0]            requested gain index
//   mute_i                        soft-mute request (effective target 0)
//   PDATA_LEFT_i/RIGHT_i [23:0]   signed input samples
//   PDATA_VALID_i                 single-cycle input frame strobe
//   PDATA_LEFT_o/RIGHT_o [23:0]   signed scaled samples, held between frames
//   PDATA_VALID_o                 single-cycle output frame strobe
//   gain_idx_o [4:0]              gain index currently applied
//   busy_o                        high while a frame is in flight
//   drop_o                        one-cycle pulse for a frame rejected while busy
// -----------------------------------------------------------------------------
module apu_gain_sequencer #(
    parameter int unsigned RAMP_DIV = 4
) (
    input  logic        MCLK_i,
    input  logic        nRst_int_w,
    input  logic [4:0]  target_amp_i,
    input  logic        mute_i,
    input  logic [23:0] PDATA_LEFT_i,
    input  logic [23:0] PDATA_RIGHT_i,
    input  logic        PDATA_VALID_i,
    output logic [23:0] PDATA_LEFT_o,
    output logic [23:0] PDATA_RIGHT_o,
    output logic        PDATA_VALID_o,
    output logic [4:0]  gain_idx_o,
    output logic        busy_o,
    output logic        drop_o
);

    if (RAMP_DIV < 1 || RAMP_DIV > 255) begin : g_bad_ramp_div
        $error("apu_gain_sequencer: RAMP_DIV must be in 1..255");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MUL_L = 2'd1,
        ST_MUL_R = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [6:0] gain_factor(input logic [4:0] idx);
        logic [6:0] f;
        case (idx)
            5'd0:  f = 7'd1;    5'd1:  f = 7'd2;    5'd2:  f = 7'd3;    5'd3:  f = 7'd4;
            5'd4:  f = 7'd5;    5'd5:  f = 7'd6;    5'd6:  f = 7'd7;    5'd7:  f = 7'd8;
            5'd8:  f = 7'd9;    5'd9:  f = 7'd10;   5'd10: f = 7'd11;   5'd11: f = 7'd13;
            5'd12: f = 7'd14;   5'd13: f = 7'd16;   5'd14: f = 7'd18;   5'd15: f = 7'd20;
            5'd16: f = 7'd23;   5'd17: f = 7'd25;   5'd18: f = 7'd29;   5'd19: f = 7'd32;
            5'd20: f = 7'd36;   5'd21: f = 7'd40;   5'd22: f = 7'd45;   5'd23: f = 7'd51;
            5'd24: f = 7'd57;   5'd25: f = 7'd64;   5'd26: f = 7'd72;   5'd27: f = 7'd80;
            5'd28: f = 7'd90;   5'd29: f = 7'd101;  5'd30: f = 7'd114;  default: f = 7'd127;
        endcase
        return f;
    endfunction

    // Product bits [32:28] must all be sign copies for [28:5] to be exact;
    // otherwise clamp to full scale of the product's sign.
    function automatic logic [23:0] saturate(input logic [32:0] p);
        logic [23:0] s;
        if (p[32:28] == 5'b00000 || p[32:28] == 5'b11111) begin
            s = p[28:5];
        end else if (p[32]) begin
            s = 24'h800000;
        end else begin
            s = 24'h7FFFFF;
        end
        return s;
    endfunction

    state_t      state_q,     state_d;
    logic [23:0] left_cap_q,  left_cap_d;
    logic [23:0] right_cap_q, right_cap_d;
    logic [4:0]  tgt_cap_q,   tgt_cap_d;
    logic        mute_cap_q,  mute_cap_d;
    logic [32:0] prod_q,      prod_d;
    logic [23:0] left_out_q,  left_out_d;
    logic [23:0] right_out_q, right_out_d;
    logic        valid_q,     valid_d;
    logic        busy_q,      busy_d;
    logic        drop_q,      drop_d;
    logic [4:0]  gain_q,      gain_d;
`ifdef APU_GAIN_RAMP_EN
    localparam logic [7:0] RAMP_LAST = 8'(RAMP_DIV - 1);
    logic [7:0]  cnt_q,       cnt_d;
`endif

    // Shared multiplier. A muted frame at index 0 multiplies by zero, which
    // gives an exact 24'h000000 on both channels.
    logic [6:0]         factor;
    logic signed [9:0]  mul_a;
    logic signed [23:0] mul_b;
    logic signed [32:0] mul_p;
    logic [4:0]         eff_target;

    assign factor     = (mute_cap_q && gain_q == 5'd0) ? 7'd0 : gain_factor(gain_q);
    assign mul_a      = signed'({3'b000, factor});
    assign mul_b      = signed'((state_q == ST_MUL_R) ? right_cap_q : left_cap_q);
    // |factor * sample| < 2^30, so 33 bits hold every product exactly.
    assign mul_p      = 33'(mul_a) * 33'(mul_b);
    assign eff_target = mute_cap_q ? 5'd0 : tgt_cap_q;

    always_comb begin
        state_d     = state_q;
        left_cap_d  = left_cap_q;
        right_cap_d = right_cap_q;
        tgt_cap_d   = tgt_cap_q;
        mute_cap_d  = mute_cap_q;
        prod_d      = prod_q;
        left_out_d  = left_out_q;
        right_out_d = right_out_q;
        valid_d     = 1'b0;
        gain_d      = gain_q;
`ifdef APU_GAIN_RAMP_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // Target and mute are captured with the samples so that later
                // changes cannot touch the frame in flight.
                if (PDATA_VALID_i) begin
                    left_cap_d  = PDATA_LEFT_i;
                    right_cap_d = PDATA_RIGHT_i;
                    tgt_cap_d   = target_amp_i;
                    mute_cap_d  = mute_i;
                    state_d     = ST_MUL_L;
                end
            end
            ST_MUL_L: begin
                prod_d  = mul_p;
                state_d = ST_MUL_R;
            end
            ST_MUL_R: begin
                prod_d     = mul_p;
                left_out_d = saturate(prod_q);
                state_d    = ST_DONE;
            end
            default: begin
                right_out_d = saturate(prod_q);
                valid_d     = 1'b1;
                state_d     = ST_IDLE;
`ifdef APU_GAIN_RAMP_EN
                if (cnt_q == RAMP_LAST) begin
                    cnt_d = 8'd0;
                    if (gain_q < eff_target) begin
                        gain_d = gain_q + 5'd1;
                    end else if (gain_q > eff_target) begin
                        gain_d = gain_q - 5'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`else
                gain_d = eff_target;
`endif
            end
        endcase
        drop_d = PDATA_VALID_i && (state_q != ST_IDLE);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge MCLK_i or negedge nRst_int_w) begin
        if (!nRst_int_w) begin
            state_q     <= ST_IDLE;
            left_cap_q  <= 24'd0;
            right_cap_q <= 24'd0;
            tgt_cap_q   <= 5'd0;
            mute_cap_q  <= 1'b0;
            prod_q      <= 33'd0;
            left_out_q  <= 24'd0;
            right_out_q <= 24'd0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            drop_q      <= 1'b0;
            gain_q      <= 5'd0;
`ifdef APU_GAIN_RAMP_EN
            cnt_q       <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            left_cap_q  <= left_cap_d;
            right_cap_q <= right_cap_d;
            tgt_cap_q   <= tgt_cap_d;
            mute_cap_q  <= mute_cap_d;
            prod_q      <= prod_d;
            left_out_q  <= left_out_d;
            right_out_q <= right_out_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            drop_q      <= drop_d;
            gain_q      <= gain_d;
`ifdef APU_GAIN_RAMP_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign PDATA_LEFT_o  = left_out_q;
    assign PDATA_RIGHT_o = right_out_q;
    assign PDATA_VALID_o = valid_q;
    assign gain_idx_o    = gain_q;
    assign busy_o        = busy_q;
    assign drop_o        = drop_q;

endmodule

// File: tb/tb_apu_gain_sequencer.sv
// -----------------------------------------------------------------------------
// tb_apu_gain_sequencer
//
// Drives frames into apu_gain_sequencer and compares every output frame with a
// reference model: factor table lookup, integer multiply, divide by 32 with
// clamping to the 24-bit range, plus a frame-count based gain ramp (or direct
// load when APU_GAIN_RAMP_EN is not defined).
// -----------------------------------------------------------------------------
module tb_apu_gain_sequencer;

    localparam int RAMP_DIV = 4;

    logic        MCLK_i = 1'b0;
    logic        nRst_int_w = 1'b0;
    logic [4:0]  target_amp_i = 5'd0;
    logic        mute_i = 1'b0;
    logic [23:0] PDATA_LEFT_i = 24'd0;
    logic [23:0] PDATA_RIGHT_i = 24'd0;
    logic        PDATA_VALID_i = 1'b0;
    logic [23:0] PDATA_LEFT_o;
    logic [23:0] PDATA_RIGHT_o;
    logic        PDATA_VALID_o;
    logic [4:0]  gain_idx_o;
    logic        busy_o;
    logic        drop_o;

    apu_gain_sequencer #(.RAMP_DIV(RAMP_DIV)) dut (
        .MCLK_i        (MCLK_i),
        .nRst_int_w    (nRst_int_w),
        .target_amp_i  (target_amp_i),
        .mute_i        (mute_i),
        .PDATA_LEFT_i  (PDATA_LEFT_i),
        .PDATA_RIGHT_i (PDATA_RIGHT_i),
        .PDATA_VALID_i (PDATA_VALID_i),
        .PDATA_LEFT_o  (PDATA_LEFT_o),
        .PDATA_RIGHT_o (PDATA_RIGHT_o),
        .PDATA_VALID_o (PDATA_VALID_o),
        .gain_idx_o    (gain_idx_o),
        .busy_o        (busy_o),
        .drop_o        (drop_o)
    );

    always #5 MCLK_i = ~MCLK_i;

    int checks = 0;
    int errors = 0;
    int vld_cnt = 0;
    int drop_cnt = 0;

    always @(negedge MCLK_i) begin
        if (PDATA_VALID_o === 1'b1) vld_cnt++;
        if (drop_o === 1'b1) drop_cnt++;
    end

    // Reference model state
    int factor_tab[32] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 13, 14, 16, 18, 20,
                           23, 25, 29, 32, 36, 40, 45, 51, 57, 64, 72, 80, 90, 101, 114, 127};
    int m_gain = 0;
    int m_frames = 0;

    function automatic logic [23:0] exp_sample(int g, bit mut, logic [23:0] s);
        longint p;
        if (mut && g == 0) return 24'h000000;
        p = longint'(factor_tab[g]) * longint'($signed(s));
        p = p >>> 5;
        if (p > 64'sd8388607) return 24'h7FFFFF;
        if (p < -64'sd8388608) return 24'h800000;
        return p[23:0];
    endfunction

    function automatic void model_done(int tgt, bit mut);
        int eff;
        eff = mut ? 0 : tgt;
`ifdef APU_GAIN_RAMP_EN
        m_frames++;
        if (m_frames == RAMP_DIV) begin
            m_frames = 0;
            if (m_gain < eff) m_gain++;
            else if (m_gain > eff) m_gain--;
        end
`else
        m_gain = eff;
`endif
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One complete frame: drive, optionally inject a second strobe 2 cycles
    // later, perturb target/mute while in flight, then check the result.
    task automatic run_frame(logic [23:0] l, logic [23:0] r, int tgt, bit mut,
                             bit inject, string tag);
        logic [23:0] el;
        logic [23:0] er;
        int cyc;
        int v0;
        int d0;
        el = exp_sample(m_gain, mut, l);
        er = exp_sample(m_gain, mut, r);
        @(negedge MCLK_i);
        PDATA_LEFT_i  = l;
        PDATA_RIGHT_i = r;
        target_amp_i  = 5'(tgt);
        mute_i        = mut;
        PDATA_VALID_i = 1'b1;
        v0 = vld_cnt;
        d0 = drop_cnt;
        @(negedge MCLK_i);
        PDATA_VALID_i = 1'b0;
        target_amp_i  = 5'($urandom);
        mute_i        = 1'($urandom);
        PDATA_LEFT_i  = 24'($urandom);
        PDATA_RIGHT_i = 24'($urandom);
        cyc = 1;
        while (PDATA_VALID_o !== 1'b1 && cyc < 12) begin
            if (cyc == 2) begin
                check({tag, "/busy"}, 32'(busy_o), 32'd1);
                if (inject) begin
                    PDATA_VALID_i = 1'b1;
                    PDATA_LEFT_i  = 24'($urandom);
                    PDATA_RIGHT_i = 24'($urandom);
                end
            end
            @(negedge MCLK_i);
            PDATA_VALID_i = 1'b0;
            cyc++;
        end
        model_done(tgt, mut);
        check({tag, "/latency"}, 32'(cyc), 32'd4);
        check({tag, "/left"}, 32'(PDATA_LEFT_o), 32'(el));
        check({tag, "/right"}, 32'(PDATA_RIGHT_o), 32'(er));
        check({tag, "/gain"}, 32'(gain_idx_o), 32'(m_gain));
        @(negedge MCLK_i);
        check({tag, "/valid_pulse"}, 32'(PDATA_VALID_o), 32'd0);
        check({tag, "/left_hold"}, 32'(PDATA_LEFT_o), 32'(el));
        check({tag, "/right_hold"}, 32'(PDATA_RIGHT_o), 32'(er));
        check({tag, "/idle"}, 32'(busy_o), 32'd0);
        @(negedge MCLK_i);
        check({tag, "/valid_count"}, 32'(vld_cnt - v0), 32'd1);
        check({tag, "/drop_count"}, 32'(drop_cnt - d0), inject ? 32'd1 : 32'd0);
    endtask

    initial begin
        int v0;
        logic [23:0] sl [4];
        logic [23:0] sr [4];
        sl[0] = 24'h200000; sr[0] = 24'hE00000;
        sl[1] = 24'h400000; sr[1] = 24'hC00000;
        sl[2] = 24'h7FFFFF; sr[2] = 24'h800000;

        // Reset state
        #1;
        check("reset/left", 32'(PDATA_LEFT_o), 32'd0);
        check("reset/right", 32'(PDATA_RIGHT_o), 32'd0);
        check("reset/valid", 32'(PDATA_VALID_o), 32'd0);
        check("reset/busy", 32'(busy_o), 32'd0);
        check("reset/gain", 32'(gain_idx_o), 32'd0);
        check("reset/drop", 32'(drop_o), 32'd0);
        repeat (3) @(negedge MCLK_i);
        nRst_int_w = 1'b1;

        // Unity-gain directed frames
        for (int i = 0; i < 4; i++) run_frame(24'h100000, 24'hF00000, 19, 1'b0, 1'b0, "unity");

        // Ramp toward unity with random samples
        for (int i = 0; i < 80; i++)
            run_frame(24'($urandom), 24'($urandom), 19, 1'b0, 1'b0, "rampup");

        // Maximum gain, including saturating inputs
        for (int i = 0; i < 60; i++) begin
            sl[3] = 24'($urandom);
            sr[3] = 24'($urandom);
            run_frame(sl[i % 4], sr[i % 4], 31, 1'b0, 1'b0, "maxgain");
        end

        // Strobe arriving while busy
        for (int i = 0; i < 3; i++)
            run_frame(24'($urandom), 24'($urandom), 31, 1'b0, 1'b1, "drop");

        // Soft mute down to zero, then release
        for (int i = 0; i < 140; i++)
            run_frame(24'($urandom), 24'($urandom), int'($urandom_range(0, 31)), 1'b1, 1'b0, "mute");
        for (int i = 0; i < 60; i++)
            run_frame(24'($urandom), 24'($urandom), 12, 1'b0, 1'b0, "unmute");

        // Fully random traffic
        for (int i = 0; i < 60; i++)
            run_frame(24'($urandom), 24'($urandom), int'($urandom_range(0, 31)),
                      ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), "random");

        // Reset while the frame is in MUL_R
        @(negedge MCLK_i);
        PDATA_LEFT_i  = 24'h123456;
        PDATA_RIGHT_i = 24'h654321;
        PDATA_VALID_i = 1'b1;
        v0 = vld_cnt;
        @(negedge MCLK_i);
        PDATA_VALID_i = 1'b0;
        @(negedge MCLK_i);
        check("midrst/busy_before", 32'(busy_o), 32'd1);
        nRst_int_w = 1'b0;
        #1;
        check("midrst/left", 32'(PDATA_LEFT_o), 32'd0);
        check("midrst/right", 32'(PDATA_RIGHT_o), 32'd0);
        check("midrst/valid", 32'(PDATA_VALID_o), 32'd0);
        check("midrst/busy", 32'(busy_o), 32'd0);
        check("midrst/gain", 32'(gain_idx_o), 32'd0);
        check("midrst/drop", 32'(drop_o), 32'd0);
        m_gain = 0;
        m_frames = 0;
        repeat (2) @(negedge MCLK_i);
        nRst_int_w = 1'b1;
        repeat (6) @(negedge MCLK_i);
        check("midrst/no_valid", 32'(vld_cnt - v0), 32'd0);
        check("midrst/gain_after", 32'(gain_idx_o), 32'd0);

        // Soft start after reset
        for (int i = 0; i < 3; i++)
            run_frame(24'h100000, 24'hF00000, 19, 1'b0, 1'b0, "softstart");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
